// File: rtl/uart_row_tx_if.sv
// Row-echo port bundle: the start request, the char-index/char-byte row read bus
// and the serial line with its status flags.
interface uart_row_tx_if;
  // start is a single-cycle request, sampled only while busy=0 (never queued).
  // charByte must be valid no later than 2 clocks after charIndex changes.
  logic       start;
  logic [3:0] charIndex;
  logic [7:0] charByte;
  logic       uartTx;
  logic       busy;
  logic       done;
  logic [2:0] stateDbg;

  modport master (
    input  start,
    input  charByte,
    output charIndex,
    output uartTx,
    output busy,
    output done,
    output stateDbg
  );

  modport slave (
    output start,
    output charByte,
    input  charIndex,
    input  uartTx,
    input  busy,
    input  done,
    input  stateDbg
  );
endinterface

// File: rtl/uart_row_tx.sv
// Walks one display row through the char-index/char-byte bus and sends each
// character as UART 8N1 (LSB first), optionally followed by CR LF.
module uart_row_tx #(
  parameter int DELAY_FRAMES = 234,
  parameter int ROW_CHARS    = 16,
  parameter int APPEND_CRLF  = 1
) (
  input  logic          clk,
  input  logic          resetN,
  uart_row_tx_if.master row
);

  localparam int TOTAL_CHARS = ROW_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int DW          = $clog2(DELAY_FRAMES);

  localparam logic [DW-1:0] DLY_LAST     = DW'(DELAY_FRAMES - 1);
  localparam logic [4:0]    ROW_CNT      = 5'(ROW_CHARS);
  localparam logic [4:0]    LAST_CHAR    = 5'(TOTAL_CHARS - 1);
  localparam logic [3:0]    LAST_ROW_IDX = 4'(ROW_CHARS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    START_BIT = 3'd2,
    DATA_BITS = 3'd3,
    STOP_BIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t        state,      state_n;
  logic [DW-1:0] delay_cnt,  delay_cnt_n;
  logic [2:0]    bit_idx,    bit_idx_n;
  logic [4:0]    char_count, char_count_n;
  logic          fetch_cnt,  fetch_cnt_n;
  logic [7:0]    tx_byte,    tx_byte_n;
  logic [3:0]    char_index, char_index_n;

  logic [4:0]    count_inc;
  logic          bit_end;

  assign count_inc = char_count + 5'd1;
  assign bit_end   = (delay_cnt == DLY_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      delay_cnt  <= '0;
      bit_idx    <= '0;
      char_count <= '0;
      fetch_cnt  <= 1'b0;
      tx_byte    <= '0;
      char_index <= '0;
    end else begin
      state      <= state_n;
      delay_cnt  <= delay_cnt_n;
      bit_idx    <= bit_idx_n;
      char_count <= char_count_n;
      fetch_cnt  <= fetch_cnt_n;
      tx_byte    <= tx_byte_n;
      char_index <= char_index_n;
    end
  end

  always_comb begin
    state_n      = state;
    delay_cnt_n  = delay_cnt;
    bit_idx_n    = bit_idx;
    char_count_n = char_count;
    fetch_cnt_n  = fetch_cnt;
    tx_byte_n    = tx_byte;
    char_index_n = char_index;

    case (state)
      IDLE: begin
        if (row.start) begin
          char_count_n = '0;
          char_index_n = '0;
          fetch_cnt_n  = 1'b0;
          delay_cnt_n  = '0;
          state_n      = FETCH;
        end
      end

      // Two clocks give both combinational and registered row sources time
      // to present the byte for the current index.
      FETCH: begin
        if (!fetch_cnt) begin
          fetch_cnt_n = 1'b1;
        end else begin
          fetch_cnt_n = 1'b0;
          delay_cnt_n = '0;
          state_n     = START_BIT;
          if (char_count < ROW_CNT) begin
            tx_byte_n = row.charByte;
          end else if (char_count == ROW_CNT) begin
            tx_byte_n = 8'h0D;
          end else begin
            tx_byte_n = 8'h0A;
          end
        end
      end

      START_BIT: begin
        if (bit_end) begin
          delay_cnt_n = '0;
          bit_idx_n   = '0;
          state_n     = DATA_BITS;
        end else begin
          delay_cnt_n = delay_cnt + 1'b1;
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          delay_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP_BIT;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          delay_cnt_n = delay_cnt + 1'b1;
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          delay_cnt_n  = '0;
          char_count_n = count_inc;
          if (char_count == LAST_CHAR) begin
            state_n = DONE;
          end else begin
            state_n = FETCH;
            // The index parks on the last row character while CR/LF go out.
            char_index_n = (count_inc < ROW_CNT) ? count_inc[3:0] : LAST_ROW_IDX;
          end
        end else begin
          delay_cnt_n = delay_cnt + 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Line and flags decode straight from state so reset forces them at once.
  always_comb begin
    row.uartTx = 1'b1;
    if (state == START_BIT) begin
      row.uartTx = 1'b0;
    end else if (state == DATA_BITS) begin
      row.uartTx = tx_byte[bit_idx];
    end
  end

  assign row.busy      = (state == FETCH) || (state == START_BIT) ||
                         (state == DATA_BITS) || (state == STOP_BIT);
  assign row.done      = (state == DONE);
  assign row.charIndex = char_index;
  assign row.stateDbg  = state;

endmodule

// File: tb/tb_uart_row_tx.sv
// Directed bench for uart_row_tx: one instance without CR/LF, one with, both
// at 4 clocks per bit, decoded by a strict bit-timing receiver.
module tb_uart_row_tx;

  localparam int DF = 4;

  logic clk;
  logic resetN;

  uart_row_tx_if if0 ();
  uart_row_tx_if if1 ();

  uart_row_tx #(.DELAY_FRAMES(DF), .ROW_CHARS(16), .APPEND_CRLF(0)) dut0 (
    .clk(clk), .resetN(resetN), .row(if0.master)
  );

  uart_row_tx #(.DELAY_FRAMES(DF), .ROW_CHARS(16), .APPEND_CRLF(1)) dut1 (
    .clk(clk), .resetN(resetN), .row(if1.master)
  );

  // ---------------- clock / reset / row sources ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] const0, const1, reg_byte0;
  logic       src_reg0;

  always @(posedge clk) reg_byte0 <= 8'h30 + {4'h0, if0.charIndex};

  assign if0.charByte = src_reg0 ? reg_byte0 : const0;
  assign if1.charByte = const1;

  int cyc = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  always @(posedge clk) begin
    if (if0.done === 1'b1) done_cnt0++;
    if (if1.done === 1'b1) done_cnt1++;
    cyc++;
  end

  logic       sel;
  logic       tx_mon, busy_mon, done_mon;
  logic [3:0] idx_mon;

  assign tx_mon   = sel ? if1.uartTx    : if0.uartTx;
  assign busy_mon = sel ? if1.busy      : if0.busy;
  assign done_mon = sel ? if1.done      : if0.done;
  assign idx_mon  = sel ? if1.charIndex : if0.charIndex;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int busy_bad = 0;
  int rx_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_start(input logic v);
    if (sel) if1.start = v;
    else     if0.start = v;
  endtask

  task automatic pulse(output int t);
    @(negedge clk);
    set_start(1'b1);
    t = cyc;
    @(negedge clk);
    set_start(1'b0);
  endtask

  task automatic wait_low(output logic ok);
    int t;
    t = 0;
    while (tx_mon !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 3000);
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  // Samples all 40 clocks of a frame; every bit must hold for exactly DF clocks.
  task automatic rx_byte(output logic [7:0] b, output logic [3:0] idx);
    logic ok, v, found;
    b = '0;
    wait_low(found);
    rx_cyc = cyc;
    idx = idx_mon;
    if (!found) return;
    ok = 1'b1;
    for (int bi = 0; bi < 10; bi++) begin
      v = tx_mon;
      for (int k = 0; k < DF; k++) begin
        if (tx_mon !== v) ok = 1'b0;
        if (busy_mon !== 1'b1) busy_bad++;
        if (!(bi == 9 && k == DF - 1)) @(negedge clk);
      end
      if (bi == 0 && v !== 1'b0) ok = 1'b0;
      if (bi == 9 && v !== 1'b1) ok = 1'b0;
      if (bi >= 1 && bi <= 8) b[bi-1] = v;
    end
    check("frame_shape", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done_hi();
    int t;
    t = 0;
    while (done_mon !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b;
    logic [3:0] idx;
    logic       ok;
    int         t0, tmp, d0;

    resetN   = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    const0   = 8'h41;
    const1   = 8'h20;
    src_reg0 = 1'b0;
    sel      = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx0",    {31'd0, if0.uartTx}, 32'd1);
    check("rst_busy0",  {31'd0, if0.busy},   32'd0);
    check("rst_done0",  {31'd0, if0.done},   32'd0);
    check("rst_idx0",   {28'd0, if0.charIndex}, 32'd0);
    check("rst_state0", {29'd0, if0.stateDbg},  32'd0);
    check("rst_tx1",    {31'd0, if1.uartTx}, 32'd1);
    check("rst_busy1",  {31'd0, if1.busy},   32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Basic row of 'A', with a start pulse mid-transfer and one in the DONE cycle.
    busy_bad = 0;
    d0 = done_cnt0;
    pulse(t0);
    for (int i = 0; i < 16; i++) begin
      rx_byte(b, idx);
      if (i == 0) check("first_start_lat", rx_cyc - t0, 32'd3);
      check("basic_byte", {24'd0, b}, 32'h41);
      if (i == 4) pulse(tmp);
    end
    wait_done_hi();
    // done is high in the clock between edge 673 and edge 674 after start.
    check("done_lat", cyc - t0, 32'd673);
    check("busy_in_done", {31'd0, busy_mon}, 32'd0);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    ok = 1'b1;
    repeat (60) begin
      if (tx_mon !== 1'b1 || busy_mon !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("ignored_start_quiet", {31'd0, ok}, 32'd1);
    check("done_once", done_cnt0 - d0, 32'd1);
    check("busy_during_xfer", busy_bad, 32'd0);

    // Bit order, then restart on the cycle right after done.
    const0 = 8'hA5;
    pulse(t0);
    rx_byte(b, idx);
    check("bit_order_a5", {24'd0, b}, 32'hA5);
    wait_done_hi();
    const0 = 8'h41;
    @(negedge clk);
    if0.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    if0.start = 1'b0;
    check("restart_busy", {31'd0, busy_mon}, 32'd1);
    rx_byte(b, idx);
    check("restart_lat", rx_cyc - t0, 32'd3);
    check("restart_byte", {24'd0, b}, 32'h41);
    rx_byte(b, idx);

    // Reset while bit 1 of 0x41 (a zero) is on the line.
    wait_low(ok);
    repeat (8) @(negedge clk);
    check("bit1_low", {31'd0, tx_mon}, 32'd0);
    check("pre_reset_idx", {28'd0, idx_mon}, 32'd2);
    resetN = 1'b0;
    #1;
    check("async_rst_tx",   {31'd0, if0.uartTx}, 32'd1);
    check("async_rst_busy", {31'd0, if0.busy},   32'd0);
    check("async_rst_idx",  {28'd0, if0.charIndex}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    // Registered source after reset: '0'..'?' in index order.
    src_reg0 = 1'b1;
    pulse(t0);
    for (int i = 0; i < 16; i++) begin
      rx_byte(b, idx);
      check("reg_src_byte", {24'd0, b}, 32'h30 + i);
      check("reg_src_idx", {28'd0, idx}, i);
    end
    wait_done_hi();

    // CR/LF instance: 16 spaces then 0x0D, 0x0A with charIndex parked at 15.
    @(negedge clk);
    sel = 1'b1;
    d0 = done_cnt1;
    pulse(t0);
    for (int i = 0; i < 18; i++) begin
      rx_byte(b, idx);
      if (i < 16) begin
        check("crlf_row_byte", {24'd0, b}, 32'h20);
      end else begin
        check("crlf_tail_byte", {24'd0, b}, (i == 16) ? 32'h0D : 32'h0A);
        check("crlf_idx_hold", {28'd0, idx}, 32'd15);
      end
    end
    wait_done_hi();
    check("crlf_done_lat", cyc - t0, 32'd757);
    repeat (3) @(negedge clk);
    check("crlf_done_once", done_cnt1 - d0, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
